// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and helpers shared by the sequential ALU
// Ports: none (package).
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_SLT   = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_md_if.sv
// rtl/alu_seq_md_if.sv - request/response bus of the sequential ALU
// Ports (signals): InValid/InReady/SrcA/SrcB/ALUControl request side,
//   OutValid/OutReady/ALUResult/ZF/SF/CF/OF/IllegalOp/DivZero response side.
//   master = pipeline driving requests, slave = ALU.
interface alu_seq_md_if #(
    parameter int WIDTH = 32
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALUControl;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] ALUResult;
    logic             ZF;
    logic             SF;
    logic             CF;
    logic             OF;
    logic             IllegalOp;
    logic             DivZero;

    modport master (
        output InValid, SrcA, SrcB, ALUControl, OutReady,
        input  InReady, OutValid, ALUResult, ZF, SF, CF, OF, IllegalOp, DivZero
    );

    modport slave (
        input  InValid, SrcA, SrcB, ALUControl, OutReady,
        output InReady, OutValid, ALUResult, ZF, SF, CF, OF, IllegalOp, DivZero
    );
endinterface

// File: rtl/alu_md_iter.sv
// rtl/alu_md_iter.sv - bit-serial shift-add multiplier / restoring divider
// Ports: clk, rst (sync active-high); start latches a/b/op_div and begins;
//   done is high during the WIDTH-th iteration cycle, when lo/hi carry the
//   final value (product low/high, or quotient/remainder) for capture.
module alu_md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   madd;
    logic [WIDTH:0]   dsh;
    logic [WIDTH-1:0] dsub;
    logic             dge;
    logic [WIDTH-1:0] step_hi, step_lo;

    // hi:lo is the 2*WIDTH accumulator for multiply (multiplier shifts out of
    // lo as the product shifts in) and remainder:quotient for divide.
    always_comb begin
        madd    = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {WIDTH{1'b0}})};
        dsh     = {hi_q, lo_q[WIDTH-1]};
        dge     = (dsh >= {1'b0, b_q});
        // Partial remainder stays below b, so the low WIDTH bits suffice.
        dsub    = dsh[WIDTH-1:0] - b_q;
        if (div_q) begin
            step_hi = dge ? dsub : dsh[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], dge};
        end else begin
            step_hi = madd[WIDTH:1];
            step_lo = {madd[0], lo_q[WIDTH-1:1]};
        end
        lo = step_lo;
        hi = step_hi;
    end

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        div_d  = div_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done   = 1'b0;
        if (start && !busy_q) begin
            busy_d = 1'b1;
            cnt_d  = CW'(WIDTH - 1);
            div_d  = op_div;
            b_d    = b;
            hi_d   = '0;
            lo_d   = a;
        end else if (busy_q) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                done   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end
endmodule

// File: rtl/alu_seq_md.sv
// rtl/alu_seq_md.sv - handshaked ALU with registered result and iterative mul/div
// Ports: clk, rst (sync active-high), bus (alu_seq_md_if.slave): request
//   InValid/InReady/SrcA/SrcB/ALUControl, response OutValid/OutReady/
//   ALUResult with ZF/SF/CF/OF/IllegalOp/DivZero.
module alu_seq_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_seq_md_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zf_q, zf_d, sf_q, sf_d, cf_q, cf_d, of_q, of_d;
    logic             ill_q, ill_d, dz_q, dz_d;

    logic [WIDTH-1:0] a, b;
    logic [3:0]       op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cf, alu_of;
    logic             accept, div_zero, illegal;
    logic             iter_start, iter_done;
    logic [WIDTH-1:0] iter_lo, iter_hi;
    logic [WIDTH-1:0] md_res;

    assign a     = bus.SrcA;
    assign b     = bus.SrcB;
    assign op    = bus.ALUControl;
    assign shamt = b[SHW-1:0];

    assign accept   = bus.InValid && (state_q == ST_IDLE);
    assign div_zero = is_div(op) && (b == '0);
    assign illegal  = (op[3:1] == 3'b111);

    // Single-cycle datapath; the DIVU/REMU arms only matter for divide by zero.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        alu_res = '0;
        alu_cf  = 1'b0;
        alu_of  = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_cf  = sum[WIDTH];
                alu_of  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_cf  = diff[WIDTH];              // borrow: a <u b
                alu_of  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL:  alu_res = a << shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_XOR:  alu_res = a ^ b;
            OP_SRL:  alu_res = a >> shamt;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_DIVU: alu_res = '1;
            OP_REMU: alu_res = a;
            default: alu_res = '0;
        endcase
    end

    alu_md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .op_div (is_div(op)),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .lo     (iter_lo),
        .hi     (iter_hi)
    );

    // MULHU and REMU take the upper half of the iterative accumulator.
    assign md_res = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? iter_hi : iter_lo;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        res_d      = res_q;
        zf_d       = zf_q;
        sf_d       = sf_q;
        cf_d       = cf_q;
        of_d       = of_q;
        ill_d      = ill_q;
        dz_d       = dz_q;
        iter_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = op;
                    if (is_multicycle(op) && !div_zero) begin
                        iter_start = 1'b1;
                        state_d    = ST_BUSY;
                    end else begin
                        state_d = ST_DONE;
                        res_d   = alu_res;
                        zf_d    = (alu_res == '0);
                        sf_d    = alu_res[WIDTH-1];
                        cf_d    = alu_cf;
                        of_d    = alu_of;
                        ill_d   = illegal;
                        dz_d    = div_zero;
                    end
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    state_d = ST_DONE;
                    res_d   = md_res;
                    zf_d    = (md_res == '0);
                    sf_d    = md_res[WIDTH-1];
                    cf_d    = 1'b0;
                    of_d    = 1'b0;
                    ill_d   = 1'b0;
                    dz_d    = 1'b0;
                end
            end
            ST_DONE: begin
                if (bus.OutReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            res_q   <= '0;
            zf_q    <= 1'b0;
            sf_q    <= 1'b0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            ill_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            cf_q    <= cf_d;
            of_q    <= of_d;
            ill_q   <= ill_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.InReady   = (state_q == ST_IDLE);
    assign bus.OutValid  = (state_q == ST_DONE);
    assign bus.ALUResult = res_q;
    assign bus.ZF        = zf_q;
    assign bus.SF        = sf_q;
    assign bus.CF        = cf_q;
    assign bus.OF        = of_q;
    assign bus.IllegalOp = ill_q;
    assign bus.DivZero   = dz_q;
endmodule

// File: tb/tb_alu_seq_md.sv
// tb/tb_alu_seq_md.sv - self-checking bench for alu_seq_md
module tb_alu_seq_md;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_md_if #(.WIDTH(W)) bus ();

    alu_seq_md #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    typedef struct {
        logic [31:0] res;
        logic        zf, sf, cf, of, ill, dz;
        int          lat;
    } exp_t;

    // Reference: plain arithmetic on the opcode's meaning.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, s;
        logic [63:0] p;
        int          sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        p  = 64'(a) * 64'(b);
        e.cf = 0; e.of = 0; e.ill = 0; e.dz = 0; e.lat = 1; e.res = '0;
        case (op)
            4'd0: begin
                e.res = a + b;
                e.cf  = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
                s     = sa + sb;
                e.of  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1:  e.res = a << sh;
            4'd2: begin
                e.res = a - b;
                e.cf  = (a < b);
                s     = sa - sb;
                e.of  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  e.res = a ^ b;
            4'd5:  e.res = a >> sh;
            4'd6:  e.res = a | b;
            4'd7:  e.res = a & b;
            4'd8:  e.res = (a < b) ? 32'd1 : 32'd0;
            4'd9:  e.res = $signed(a) >>> sh;
            4'd10: begin e.res = p[31:0];  e.lat = W + 1; end
            4'd11: begin e.res = p[63:32]; e.lat = W + 1; end
            4'd12: begin
                if (b == 0) begin e.res = 32'hFFFF_FFFF; e.dz = 1; end
                else begin e.res = a / b; e.lat = W + 1; end
            end
            4'd13: begin
                if (b == 0) begin e.res = a; e.dz = 1; end
                else begin e.res = a % b; e.lat = W + 1; end
            end
            default: e.ill = 1;
        endcase
        e.zf = (e.res == 0);
        e.sf = e.res[31];
        return e;
    endfunction

    task automatic scramble_inputs();
        bus.InValid    = 1'($urandom % 2);
        bus.SrcA       = $urandom;
        bus.SrcB       = $urandom;
        bus.ALUControl = 4'($urandom % 16);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        exp_t e;
        int   lat;
        e = model(op, a, b);
        @(negedge clk);
        check($sformatf("in_ready op%0d", op), bus.InReady, 1);
        bus.InValid = 1'b1; bus.SrcA = a; bus.SrcB = b; bus.ALUControl = op;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (!bus.OutValid && lat < 100) begin
            scramble_inputs();
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency op%0d", op), lat, e.lat);
        check($sformatf("result op%0d a=%0h b=%0h", op, a, b), bus.ALUResult, e.res);
        check($sformatf("flags zsco_id op%0d", op),
              {bus.ZF, bus.SF, bus.CF, bus.OF, bus.IllegalOp, bus.DivZero},
              {e.zf, e.sf, e.cf, e.of, e.ill, e.dz});
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                scramble_inputs();
                @(negedge clk);
            end
            check($sformatf("hold result op%0d", op), bus.ALUResult, e.res);
            check($sformatf("hold flags op%0d", op),
                  {bus.OutValid, bus.InReady, bus.ZF, bus.SF, bus.CF, bus.OF, bus.IllegalOp, bus.DivZero},
                  {1'b1, 1'b0, e.zf, e.sf, e.cf, e.of, e.ill, e.dz});
        end
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("consumed op%0d", op), {bus.OutValid, bus.InReady}, 2'b01);
        bus.OutReady = 1'b0;
    endtask

    int vcount;
    logic [3:0] rop;
    logic [31:0] ra, rb;

    initial begin
        rst = 1'b1;
        bus.InValid = 1'b0; bus.SrcA = '0; bus.SrcB = '0; bus.ALUControl = '0; bus.OutReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset outputs",
              {bus.InReady, bus.OutValid, bus.ALUResult, bus.ZF, bus.SF, bus.CF, bus.OF, bus.IllegalOp, bus.DivZero},
              {1'b1, 1'b0, 32'h0, 6'b0});

        run_op(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op(4'd2,  32'd5, 32'd5, 0);
        run_op(4'd2,  32'd3, 32'd5, 0);
        run_op(4'd9,  32'h8000_0000, 32'h0000_0024, 0);
        run_op(4'd3,  32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'd8,  32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'd10, 32'h0001_0000, 32'h0001_0000, 0);
        run_op(4'd11, 32'h0001_0000, 32'h0001_0000, 0);
        run_op(4'd12, 32'd100, 32'd7, 0);
        run_op(4'd13, 32'd100, 32'd7, 0);
        run_op(4'd12, 32'd9, 32'd0, 0);
        run_op(4'd13, 32'd9, 32'd0, 0);
        run_op(4'd4,  32'hA5A5_0F0F, 32'h5A5A_FFFF, 5);
        run_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op(4'd14, 32'h1, 32'h1, 1);
        run_op(4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(4'd2,  32'h8000_0000, 32'h0000_0001, 0);
        run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Reset in the middle of a MUL: nothing may emerge afterwards.
        @(negedge clk);
        bus.InValid = 1'b1; bus.SrcA = 32'h1234; bus.SrcB = 32'h5678; bus.ALUControl = 4'd10;
        @(posedge clk);
        @(negedge clk);
        bus.InValid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset mid-mul outputs",
              {bus.InReady, bus.OutValid, bus.ALUResult, bus.ZF, bus.SF, bus.CF, bus.OF, bus.IllegalOp, bus.DivZero},
              {1'b1, 1'b0, 32'h0, 6'b0});
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.OutValid) vcount++;
        end
        check("no out_valid after reset", vcount, 0);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom % 16);
            ra  = $urandom;
            case ($urandom % 4)
                0:       rb = 32'($urandom % 4);
                1:       rb = $urandom % 64;
                default: rb = $urandom;
            endcase
            if ($urandom % 8 == 0) ra = 32'h8000_0000;
            run_op(rop, ra, rb, int'($urandom % 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
